mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns byte/half/word accesses onto a 32-bit memory port.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses in two; otherwise they are rejected.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;
    logic            we_q;
    logic [2:0]      func3_q;
    logic [1:0]      k_q;
    logic [4:0]      rd_q;
    logic            split_q;
    logic [3:0]      be_hi_q;
    logic [31:0]     wdata_hi_q;
    logic [31:0]     addr_hi_q;
    logic [31:0]     lo_q;

    // Request decode, only consumed in StIdle.
    logic [3:0]  size_mask;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic        crossing;
    logic        legal;
    logic        reject;

    always_comb begin
        size_mask = 4'b0000;
        legal     = 1'b0;
        case (req_func3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        be_wide    = {4'b0000, size_mask} << req_addr[1:0];
        wdata_wide = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
        crossing   = ((req_func3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_func3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
        reject = !legal || (crossing && !SplitEn);
    end

    // Load alignment: the second read word supplies the upper lanes of a split load.
    logic [63:0] merged;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        merged    = (state_q == StAcc1) ? {mem_rdata, lo_q} : {32'b0, mem_rdata};
        shifted   = merged[6'({k_q, 3'b000}) +: 32];
        load_data = shifted;
        case (func3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign req_ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            func3_q    <= 3'b000;
            k_q        <= 2'b00;
            rd_q       <= 5'd0;
            split_q    <= 1'b0;
            be_hi_q    <= 4'b0000;
            wdata_hi_q <= 32'b0;
            addr_hi_q  <= 32'b0;
            lo_q       <= 32'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'b0;
            done       <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        func3_q    <= req_func3;
                        k_q        <= req_addr[1:0];
                        rd_q       <= req_rd;
                        split_q    <= crossing;
                        be_hi_q    <= be_wide[7:4];
                        wdata_hi_q <= wdata_wide[63:32];
                        addr_hi_q  <= {req_addr[31:2] + 30'd1, 2'b00};
                        cnt_q      <= '0;
                        if (reject) begin
                            state_q <= StResp;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            wb_en   <= 1'b0;
                            wb_rd   <= req_rd;
                        end else begin
                            state_q   <= StAcc0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_wide[3:0];
                            mem_wdata <= wdata_wide[31:0];
                        end
                    end
                end
                StAcc0, StAcc1: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        if ((state_q == StAcc0) && split_q) begin
                            lo_q      <= mem_rdata;
                            state_q   <= StAcc1;
                            mem_addr  <= addr_hi_q;
                            mem_be    <= be_hi_q;
                            mem_wdata <= wdata_hi_q;
                        end else begin
                            state_q <= StResp;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b0;
                            wb_rd   <= rd_q;
                            wb_en   <= !we_q && (rd_q != 5'd0);
                            if (!we_q) begin
                                wb_data <= load_data;
                            end
                        end
                    end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                        // Abort; a completed first half of a split store is left in memory.
                        state_q <= StResp;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        wb_en   <= 1'b0;
                        wb_rd   <= rd_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    wb_en   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table driven against a reactive memory model,
// completions checked through a scoreboard queue. Honours MISALIGN_SPLIT_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    always #5 clk = ~clk;

    mem_access_unit #(.ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (done),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .err       (err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] r0, r1;
        int          d0, d1;
        int          nacc;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] w1;
        logic        err;
        logic        wben;
        logic [31:0] data;
        int          cyc;
        int          reqc;
    } vec_t;

    typedef struct {
        logic        err;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [4:0] rd, logic [31:0] r0, logic [31:0] r1, int d0, int d1,
                                int nacc, logic [31:0] a0, logic [3:0] be0, logic [31:0] w0,
                                logic [31:0] a1, logic [3:0] be1, logic [31:0] w1, logic e,
                                logic wben, logic [31:0] data, int cyc, int reqc);
        vec_t v;
        v.we = we;     v.f3 = f3;   v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.r0 = r0;     v.r1 = r1;   v.d0 = d0;     v.d1 = d1;       v.nacc = nacc;
        v.a0 = a0;     v.be0 = be0; v.w0 = w0;
        v.a1 = a1;     v.be1 = be1; v.w1 = w1;
        v.err = e;     v.wben = wben; v.data = data; v.cyc = cyc;   v.reqc = reqc;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_wb_en", 32'(wb_en), 32'(e.wb_en));
                chk("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
                if (e.wb_en) chk("sb_wb_data", wb_data, e.data);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc, started, wcnt, reqc;
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        e.err = v.err; e.wb_en = v.wben; e.rd = v.rd; e.data = v.data;
        sb.push_back(e);
        req_valid = 1'b1; req_we = v.we; req_func3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 2; started = 0; wcnt = 0; reqc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_A5A5;
            if (done) begin
                got = 1'b1;
            end else begin
                if (mem_req) begin
                    reqc++;
                    if (wcnt == 0) begin
                        chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.we));
                        if (started == 0) begin
                            chk($sformatf("v%0d_addr0", idx), mem_addr, v.a0);
                            chk($sformatf("v%0d_be0", idx), 32'(mem_be), 32'(v.be0));
                            if (v.we) chk($sformatf("v%0d_wdata0", idx), mem_wdata, v.w0);
                        end else if (started == 1) begin
                            chk($sformatf("v%0d_addr1", idx), mem_addr, v.a1);
                            chk($sformatf("v%0d_be1", idx), 32'(mem_be), 32'(v.be1));
                            if (v.we) chk($sformatf("v%0d_wdata1", idx), mem_wdata, v.w1);
                        end
                        started++;
                    end
                    if (wcnt == ((started == 1) ? v.d0 : v.d1)) begin
                        mem_ack   = 1'b1;
                        mem_rdata = (started == 1) ? v.r0 : v.r1;
                        wcnt      = 0;
                    end else begin
                        wcnt++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d_done_cycle", idx), 32'(cyc), 32'(v.cyc));
        chk($sformatf("v%0d_accesses", idx), 32'(started), 32'(v.nacc));
        chk($sformatf("v%0d_req_cycles", idx), 32'(reqc), 32'(v.reqc));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
        req_addr = 32'b0; req_wdata = 32'b0; req_rd = 5'd0; mem_ack = 1'b0;
        mem_rdata = 32'b0;

        // LB sign-extend, SH lane placement
        vecs.push_back(mk(0, 3'b000, 32'h103, 0, 5'd5, 32'h80FF_0000, 0, 0, 0, 1,
                          32'h100, 4'b1000, 0, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 3, 1));
        vecs.push_back(mk(1, 3'b001, 32'h202, 32'h0000_BEEF, 5'd0, 0, 0, 0, 0, 1,
                          32'h200, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0, 0, 0, 3, 1));
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b010, 32'h301, 0, 5'd7, 32'h4433_2211, 32'h8877_6655, 0, 0, 2,
                          32'h300, 4'b1110, 0, 32'h304, 4'b0001, 0, 0, 1, 32'h5544_3322, 4, 2));
`else
        vecs.push_back(mk(0, 3'b010, 32'h301, 0, 5'd7, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
`endif
        // Never acked: 15 cycles of mem_req then abort
        vecs.push_back(mk(0, 3'b010, 32'h400, 0, 5'd3, 0, 0, 99, 0, 1,
                          32'h400, 4'b1111, 0, 0, 0, 0, 1, 0, 0, 17, 15));
        vecs.push_back(mk(0, 3'b010, 32'h500, 0, 5'd0, 32'h1234_5678, 0, 0, 0, 1,
                          32'h500, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 3'b011, 32'h600, 0, 5'd2, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 3'b001, 32'h601, 0, 5'd9, 32'h00AB_CD00, 0, 0, 0, 1,
                          32'h600, 4'b0110, 0, 0, 0, 0, 0, 1, 32'hFFFF_ABCD, 3, 1));
        vecs.push_back(mk(0, 3'b101, 32'h601, 0, 5'd10, 32'h00AB_CD00, 0, 0, 0, 1,
                          32'h600, 4'b0110, 0, 0, 0, 0, 0, 1, 32'h0000_ABCD, 3, 1));
        vecs.push_back(mk(0, 3'b100, 32'h702, 0, 5'd11, 32'h00F0_0000, 0, 0, 0, 1,
                          32'h700, 4'b0100, 0, 0, 0, 0, 0, 1, 32'h0000_00F0, 3, 1));
        vecs.push_back(mk(1, 3'b000, 32'h803, 32'h0000_00A5, 5'd0, 0, 0, 0, 0, 1,
                          32'h800, 4'b1000, 32'hA500_0000, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(1, 3'b010, 32'h900, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 0, 1,
                          32'h900, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(1, 3'b100, 32'h900, 32'h1, 5'd1, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b001, 32'hB03, 0, 5'd12, 32'h7F00_0000, 32'h0000_00FF, 0, 0, 2,
                          32'hB00, 4'b1000, 0, 32'hB04, 4'b0001, 0, 0, 1, 32'hFFFF_FF7F, 4, 2));
        vecs.push_back(mk(1, 3'b010, 32'hC02, 32'h1122_3344, 5'd0, 0, 0, 0, 0, 2,
                          32'hC00, 4'b1100, 32'h3344_0000, 32'hC04, 4'b0011, 32'h0000_1122,
                          0, 0, 0, 4, 2));
        // Second half of a split store never acked
        vecs.push_back(mk(1, 3'b010, 32'hD01, 32'hAABB_CCDD, 5'd0, 0, 0, 0, 99, 2,
                          32'hD00, 4'b1110, 32'hBBCC_DD00, 32'hD04, 4'b0001, 32'h0000_00AA,
                          1, 0, 0, 18, 16));
`else
        vecs.push_back(mk(0, 3'b001, 32'hB03, 0, 5'd12, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
        vecs.push_back(mk(1, 3'b010, 32'hC02, 32'h1122_3344, 5'd0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0));
`endif
        // Wait-stated load, last so its writeback can be checked for hold
        vecs.push_back(mk(0, 3'b010, 32'hA00, 0, 5'd4, 32'hCAFE_F00D, 0, 3, 0, 1,
                          32'hA00, 4'b1111, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 6, 4));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wb", {wb_en, wb_rd, 26'b0}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Writeback results must hold between done pulses
        repeat (4) @(posedge clk);
        #1;
        chk("hold_wb_data", wb_data, 32'hCAFE_F00D);
        chk("hold_wb_rd", 32'(wb_rd), 32'd4);
        chk("hold_err", 32'(err), 32'd0);
        chk("hold_wb_en", 32'(wb_en), 32'd0);

        // Reset during ACC0 abandons the access
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'hE00; req_rd = 5'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_rst_req_before", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(done), 32'd0);
        end
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        run_vec(vecs[0], 100);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
